pipe_stage_skid_reg: RTL and testbench

- Parametrised successor to the fetch→decode stage register: a valid/ready pipeline register with an N-entry in-order skid buffer, per-beat cancel-to-NOP, a counted discard of stale upstream responses, and a synchronous flush on exception or return.
- Sits between any two in-order pipeline stages (IF→ID first, then ID→EXE), replacing ad-hoc single-entry "memory" latches.
- Absorbs up to SKID_DEPTH beats that arrive while the downstream stage is stalled, so fixed-latency instruction-RAM responses are never lost.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/skid_fifo.sv | 75 +++++++
 rtl/pipe_stage_skid_reg.sv | 134 +++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared constants and the skid entry type for the in-order
//            pipeline stage registers.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int          C_PC_W     = 32;
    localparam int          C_INST_W   = 32;
    localparam logic [31:0] C_NOP_INST = 32'h0280_0000;
    localparam logic [31:0] C_RESET_PC = 32'h1bff_fffc;

    // One buffered beat; the stage packs it flat as {pc, inst, cancelled}.
    typedef struct packed {
        logic [C_PC_W-1:0]   pc;
        logic [C_INST_W-1:0] inst;
        logic                cancelled;
    } skid_entry_t;

endpackage
`default_nettype wire

// File: rtl/skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : skid_fifo
// Brief    : Parametrised circular buffer with push, pop, occupancy count
//            and head view. Pointers wrap naturally (DEPTH is a power of 2).
// Revision : 1.0 - initial release
// ============================================================================
module skid_fifo
    import pipe_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 65,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_wr_idx;
    logic [PTR_W-1:0]  w_rd_idx;

    generate
        if (DEPTH > 1) begin : g_ptr_wrap
            logic [PTR_W-1:0] r_wr_ptr;
            logic [PTR_W-1:0] r_rd_ptr;

            // Read/write pointers advance on pop/push and wrap on overflow.
            always_ff @(posedge clk) begin
                if (!rst || i_flush) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end

            assign w_wr_idx = r_wr_ptr;
            assign w_rd_idx = r_rd_ptr;
        end else begin : g_ptr_single
            assign w_wr_idx = '0;
            assign w_rd_idx = '0;
        end
    endgenerate

    // Storage is data-only; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[w_wr_idx] <= i_push_data;
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_count <= '0;
        end else if (i_push && !i_pop) begin
            r_count <= r_count + CNT_W'(1);
        end else if (i_pop && !i_push) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_head  = r_mem[w_rd_idx];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid_reg
// Brief    : Valid/ready pipeline register with an in-order skid buffer,
//            cancel-to-NOP, counted discard of stale responses and a
//            synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int                PC_W       = C_PC_W,
    parameter int                INST_W     = C_INST_W,
    parameter int                SKID_DEPTH = 2,
    parameter int                DISC_W     = 2,
    parameter logic [INST_W-1:0] NOP_INST   = C_NOP_INST,
    parameter logic [PC_W-1:0]   RESET_PC   = C_RESET_PC,
    localparam int               CNT_W      = $clog2(SKID_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              in_cancel,
    input  logic              discard_inc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_cancelled,
    output logic [CNT_W-1:0]  skid_count
);

    localparam int                C_DATA_W   = PC_W + INST_W + 1;
    localparam logic [DISC_W-1:0] C_DISC_MAX = '1;

    logic [DISC_W-1:0]   r_disc_cnt;
    logic                r_out_valid;
    logic [PC_W-1:0]     r_out_pc;
    logic [INST_W-1:0]   r_out_inst;
    logic                r_out_cancelled;

    logic                w_accept;
    logic                w_drop;
    logic                w_keep;
    logic [INST_W-1:0]   w_keep_inst;
    logic                w_out_free;
    logic                w_skid_empty;
    logic                w_pop;
    logic                w_load_direct;
    logic                w_push;
    logic [C_DATA_W-1:0] w_push_data;
    logic [C_DATA_W-1:0] w_head;
    logic [CNT_W-1:0]    w_skid_count;

    // in_ready looks only at registered occupancy, so a pop in a full cycle
    // raises it one cycle later.
    assign in_ready      = (w_skid_count < CNT_W'(SKID_DEPTH));
    assign w_accept      = in_valid && in_ready && !flush;
    assign w_drop        = w_accept && (r_disc_cnt != '0);
    assign w_keep        = w_accept && !w_drop;
    assign w_keep_inst   = in_cancel ? NOP_INST : in_inst;

    // Bypass only when nothing older is buffered, preserving order.
    assign w_out_free    = !r_out_valid || out_ready;
    assign w_skid_empty  = (w_skid_count == '0);
    assign w_pop         = w_out_free && !w_skid_empty && !flush;
    assign w_load_direct = w_out_free && w_skid_empty && w_keep;
    assign w_push        = w_keep && !w_load_direct;
    assign w_push_data   = {in_pc, w_keep_inst, in_cancel};

    skid_fifo #(
        .DEPTH  (SKID_DEPTH),
        .DATA_W (C_DATA_W)
    ) u_skid_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (flush),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_skid_count)
    );

    // Stale-response counter: a drop with a new increment cancels out.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_disc_cnt <= '0;
        end else if (w_drop && !discard_inc) begin
            r_disc_cnt <= r_disc_cnt - DISC_W'(1);
        end else if (discard_inc && !w_drop && (r_disc_cnt != C_DISC_MAX)) begin
            r_disc_cnt <= r_disc_cnt + DISC_W'(1);
        end
    end

    // Output register: skid head first, then a direct beat, else a bubble.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_out_valid     <= 1'b0;
            r_out_pc        <= RESET_PC;
            r_out_inst      <= '0;
            r_out_cancelled <= 1'b0;
        end else if (w_out_free) begin
            if (!w_skid_empty) begin
                r_out_valid     <= 1'b1;
                r_out_pc        <= w_head[C_DATA_W-1 -: PC_W];
                r_out_inst      <= w_head[INST_W:1];
                r_out_cancelled <= w_head[0];
            end else if (w_keep) begin
                r_out_valid     <= 1'b1;
                r_out_pc        <= in_pc;
                r_out_inst      <= w_keep_inst;
                r_out_cancelled <= in_cancel;
            end else begin
                r_out_valid     <= 1'b0;
                r_out_pc        <= '0;
                r_out_inst      <= NOP_INST;
                r_out_cancelled <= 1'b0;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_pc        = r_out_pc;
    assign out_inst      = r_out_inst;
    assign out_cancelled = r_out_cancelled;
    assign skid_count    = w_skid_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid_reg
// Brief    : Directed self-checking bench for pipe_stage_skid_reg.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid_reg;

    localparam logic [31:0] C_NOP = 32'h0280_0000;
    localparam logic [31:0] C_RPC = 32'h1bff_fffc;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_cancel;
    logic        discard_inc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_cancelled;
    logic [1:0]  skid_count;

    int n_total = 0;
    int n_bad   = 0;

    pipe_stage_skid_reg dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_inst       (in_inst),
        .in_cancel     (in_cancel),
        .discard_inc   (discard_inc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_inst      (out_inst),
        .out_cancelled (out_cancelled),
        .skid_count    (skid_count)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic c);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        in_cancel = c;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] inst, input logic c, input logic [1:0] cnt);
        check({tag, ".valid"}, 64'(out_valid), 64'(v));
        check({tag, ".pc"},    64'(out_pc), 64'(pc));
        check({tag, ".inst"},  64'(out_inst), 64'(inst));
        check({tag, ".canc"},  64'(out_cancelled), 64'(c));
        check({tag, ".cnt"},   64'(skid_count), 64'(cnt));
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; discard_inc = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick(); tick();
        check_out("reset", 1'b0, C_RPC, 32'h0, 1'b0, 2'd0);
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.disc", 64'(dut.r_disc_cnt), 64'd0);

        // Streaming with one-cycle latency
        rst = 1'b1; out_ready = 1'b1;
        drive(1'b1, 32'h1c00_0000, 32'h0000_0011, 1'b0);
        tick();
        check_out("stream0", 1'b1, 32'h1c00_0000, 32'h0000_0011, 1'b0, 2'd0);
        drive(1'b1, 32'h1c00_0004, 32'h0000_0022, 1'b0);
        tick();
        check_out("stream1", 1'b1, 32'h1c00_0004, 32'h0000_0022, 1'b0, 2'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        check_out("bubble", 1'b0, 32'h0, C_NOP, 1'b0, 2'd0);

        // Stall absorb into a two-entry skid
        out_ready = 1'b0;
        drive(1'b1, 32'h100, 32'hA1, 1'b0);
        tick();
        check_out("stall0", 1'b1, 32'h100, 32'hA1, 1'b0, 2'd0);
        drive(1'b1, 32'h104, 32'hA2, 1'b0);
        tick();
        check_out("stall1", 1'b1, 32'h100, 32'hA1, 1'b0, 2'd1);
        check("stall1.in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h108, 32'hA3, 1'b0);
        tick();
        check_out("stall2", 1'b1, 32'h100, 32'hA1, 1'b0, 2'd2);
        check("full.in_ready", 64'(in_ready), 64'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        check("hold.pc", 64'(out_pc), 64'h100);
        check("hold.in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        check_out("drain0", 1'b1, 32'h104, 32'hA2, 1'b0, 2'd1);
        check("drain0.in_ready", 64'(in_ready), 64'd1);
        tick();
        check_out("drain1", 1'b1, 32'h108, 32'hA3, 1'b0, 2'd0);
        tick();
        check("drain2.valid", 64'(out_valid), 64'd0);

        // Cancel substitutes NOP, keeps pc
        drive(1'b1, 32'h200, 32'h1234_5678, 1'b1);
        tick();
        check_out("cancel", 1'b1, 32'h200, C_NOP, 1'b1, 2'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick();

        // Discard two stale responses
        discard_inc = 1'b1;
        tick(); tick();
        discard_inc = 1'b0;
        check("disc.cnt2", 64'(dut.r_disc_cnt), 64'd2);
        drive(1'b1, 32'h300, 32'hB0, 1'b0);
        tick();
        check("disc.drop0", 64'(out_valid), 64'd0);
        check("disc.cnt1", 64'(dut.r_disc_cnt), 64'd1);
        drive(1'b1, 32'h304, 32'hB1, 1'b0);
        tick();
        check("disc.drop1", 64'(out_valid), 64'd0);
        drive(1'b1, 32'h308, 32'hB2, 1'b0);
        tick();
        check_out("disc.keep", 1'b1, 32'h308, 32'hB2, 1'b0, 2'd0);
        check("disc.cnt0", 64'(dut.r_disc_cnt), 64'd0);

        // Drop plus increment in the same cycle leaves counter unchanged
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        discard_inc = 1'b1;
        tick();
        drive(1'b1, 32'h30c, 32'hB3, 1'b0);
        tick();
        check("disc.same", 64'(dut.r_disc_cnt), 64'd1);
        check("disc.same.valid", 64'(out_valid), 64'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0);

        // Saturation at 3
        for (int i = 0; i < 5; i++) tick();
        discard_inc = 1'b0;
        check("disc.sat", 64'(dut.r_disc_cnt), 64'd3);

        // Flush clears counter
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush0.disc", 64'(dut.r_disc_cnt), 64'd0);

        // Fill skid while stalled, then flush mid-stall
        out_ready = 1'b0;
        drive(1'b1, 32'h400, 32'hC0, 1'b0); tick();
        drive(1'b1, 32'h404, 32'hC1, 1'b0); tick();
        drive(1'b1, 32'h408, 32'hC2, 1'b0); tick();
        check_out("pre_flush", 1'b1, 32'h400, 32'hC0, 1'b0, 2'd2);
        drive(1'b1, 32'h40c, 32'hC3, 1'b0);
        flush = 1'b1; discard_inc = 1'b1;
        tick();
        flush = 1'b0; discard_inc = 1'b0;
        check_out("flush", 1'b0, C_RPC, 32'h0, 1'b0, 2'd0);
        check("flush.disc", 64'(dut.r_disc_cnt), 64'd0);
        check("flush.in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        drive(1'b1, 32'h500, 32'hD0, 1'b0);
        tick();
        check_out("post_flush", 1'b1, 32'h500, 32'hD0, 1'b0, 2'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        check_out("final_bubble", 1'b0, 32'h0, C_NOP, 1'b0, 2'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
